mem_access_stage: RTL and testbench

//  Consumer end of the EX kick_up handshake. Captures ALU_result/store data on an ALU_kick_up pulse,

---
 rtl/mem_access_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access stage between EX and WB of the multi-cycle core.
// Accepts an ALU_kick_up pulse and captures the operands. Performs at most one load or
// store over a req/ack data-memory port. Then reports the result to write-back with a
// one-cycle MEM_kick_up pulse.
// Optional feature: define MEM_MISALIGN_TRAP_EN to add the MEM_fault output. With it,
// misaligned half/word accesses are trapped instead of issued.
module mem_access_stage #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ALU_kick_up,
    input  logic [31:0] ALU_result,
    input  logic [31:0] reg_read_data_2,
    input  logic        Controller_memread,
    input  logic        Controller_memwrite,
    input  logic [2:0]  Controller_memsize,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] MEM_result,
    output logic        MEM_kick_up,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        MEM_fault,
`endif
    output logic        MEM_busy
);

    localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} kind_t;

    // Access width from funct3; any undefined code behaves as a full word.
    function automatic kind_t size_kind(input logic [2:0] sz);
        case (sz)
            3'b000, 3'b100: size_kind = SZ_B;
            3'b001, 3'b101: size_kind = SZ_H;
            default:        size_kind = SZ_W;
        endcase
    endfunction

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [31:0]      result_reg, result_next;
    logic [31:0]      addr_reg;
    logic [31:0]      data_reg;
    logic [2:0]       size_reg;
    logic             write_reg;
    logic             mem_op_in;
    logic             in_req;
    logic [7:0]       rd_byte [4];
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;
    logic [31:0]      load_data;
`ifdef MEM_MISALIGN_TRAP_EN
    logic             fault_reg, fault_next;
    logic             misalign_in;
`endif

    assign mem_op_in = Controller_memread | Controller_memwrite;
    assign in_req    = (state_reg == REQ);

`ifdef MEM_MISALIGN_TRAP_EN
    // Half needs an even address, word needs a 4-byte aligned one; bytes never trap.
    always_comb begin
        misalign_in = 1'b0;
        if (mem_op_in) begin
            case (size_kind(Controller_memsize))
                SZ_H:    misalign_in = ALU_result[0];
                SZ_W:    misalign_in = (ALU_result[1:0] != 2'b00);
                default: misalign_in = 1'b0;
            endcase
        end
    end
`endif

    // Read-data lanes, one byte per lane.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
            assign rd_byte[gi] = dmem_rdata[8*gi +: 8];
        end
    endgenerate

    // Pick the addressed lane and extend it to 32 bits.
    always_comb begin
        sel_byte  = rd_byte[addr_reg[1:0]];
        sel_half  = addr_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_data = dmem_rdata;
        case (size_kind(size_reg))
            SZ_B:    load_data = size_reg[2] ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            SZ_H:    load_data = size_reg[2] ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
            default: load_data = dmem_rdata;
        endcase
    end

    // Memory-port outputs are driven only while the request is outstanding.
    always_comb begin
        dmem_req   = in_req;
        dmem_we    = in_req & write_reg;
        dmem_addr  = 32'h0;
        dmem_be    = 4'b0000;
        dmem_wdata = 32'h0;
        if (in_req) begin
            dmem_addr = {addr_reg[31:2], 2'b00};
            case (size_kind(size_reg))
                SZ_B: begin
                    dmem_be    = 4'b0001 << addr_reg[1:0];
                    dmem_wdata = {4{data_reg[7:0]}};
                end
                SZ_H: begin
                    dmem_be    = addr_reg[1] ? 4'b1100 : 4'b0011;
                    dmem_wdata = {2{data_reg[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = data_reg;
                end
            endcase
        end
    end

    // Operand capture on an accepted kick; inputs are ignored at all other times.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg  <= 32'h0;
            data_reg  <= 32'h0;
            size_reg  <= 3'b000;
            write_reg <= 1'b0;
        end else if (state_reg == IDLE && ALU_kick_up) begin
            addr_reg  <= ALU_result;
            data_reg  <= reg_read_data_2;
            size_reg  <= Controller_memsize;
            write_reg <= Controller_memwrite;
        end
    end

    // Next-state, wait counter and result selection for the IDLE/REQ/DONE sequence.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        result_next   = result_reg;
`ifdef MEM_MISALIGN_TRAP_EN
        fault_next    = fault_reg;
`endif
        case (state_reg)
            IDLE: begin
                wait_cnt_next = '0;
                if (ALU_kick_up) begin
                    if (mem_op_in) begin
                        state_next = REQ;
                    end else begin
                        state_next  = DONE;
                        result_next = ALU_result;
`ifdef MEM_MISALIGN_TRAP_EN
                        fault_next  = 1'b0;
`endif
                    end
`ifdef MEM_MISALIGN_TRAP_EN
                    if (misalign_in) begin
                        state_next  = DONE;
                        result_next = 32'h0;
                        fault_next  = 1'b1;
                    end
`endif
                end
            end
            REQ: begin
                if (dmem_ack) begin
                    state_next  = DONE;
                    result_next = write_reg ? 32'h0 : load_data;
`ifdef MEM_MISALIGN_TRAP_EN
                    fault_next  = 1'b0;
`endif
                end else if (wait_cnt_reg == CNT_LAST) begin
                    state_next  = DONE;
                    result_next = 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
                    fault_next  = 1'b1;
`endif
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, wait counter and held result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            result_reg   <= 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
            fault_reg    <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            result_reg   <= result_next;
`ifdef MEM_MISALIGN_TRAP_EN
            fault_reg    <= fault_next;
`endif
        end
    end

    assign MEM_result  = result_reg;
    assign MEM_kick_up = (state_reg == DONE);
    assign MEM_busy    = in_req;
`ifdef MEM_MISALIGN_TRAP_EN
    assign MEM_fault   = fault_reg;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ALU_kick_up;
    logic [31:0] ALU_result;
    logic [31:0] reg_read_data_2;
    logic        Controller_memread;
    logic        Controller_memwrite;
    logic [2:0]  Controller_memsize;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] MEM_result;
    logic        MEM_kick_up;
    logic        MEM_busy;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        MEM_fault;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.WAIT_LIMIT(16)) dut (
        .clk                 (clk),
        .reset               (reset),
        .ALU_kick_up         (ALU_kick_up),
        .ALU_result          (ALU_result),
        .reg_read_data_2     (reg_read_data_2),
        .Controller_memread  (Controller_memread),
        .Controller_memwrite (Controller_memwrite),
        .Controller_memsize  (Controller_memsize),
        .dmem_req            (dmem_req),
        .dmem_we             (dmem_we),
        .dmem_addr           (dmem_addr),
        .dmem_be             (dmem_be),
        .dmem_wdata          (dmem_wdata),
        .dmem_ack            (dmem_ack),
        .dmem_rdata          (dmem_rdata),
        .MEM_result          (MEM_result),
        .MEM_kick_up         (MEM_kick_up),
`ifdef MEM_MISALIGN_TRAP_EN
        .MEM_fault           (MEM_fault),
`endif
        .MEM_busy            (MEM_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One-cycle kick; operands are then scrambled to prove they were captured.
    task automatic kick(input logic [31:0] a, input logic [31:0] d,
                        input logic rd, input logic wr, input logic [2:0] sz);
        ALU_kick_up         = 1'b1;
        ALU_result          = a;
        reg_read_data_2     = d;
        Controller_memread  = rd;
        Controller_memwrite = wr;
        Controller_memsize  = sz;
        tick();
        ALU_kick_up         = 1'b0;
        ALU_result          = 32'hAAAA_5555;
        reg_read_data_2     = 32'h5555_AAAA;
        Controller_memread  = 1'b0;
        Controller_memwrite = 1'b0;
        Controller_memsize  = 3'b111;
    endtask

    initial begin
        int req_cycles;
        int pulses;

        reset = 1'b1;
        ALU_kick_up = 1'b0;
        ALU_result = 32'h0;
        reg_read_data_2 = 32'h0;
        Controller_memread = 1'b0;
        Controller_memwrite = 1'b0;
        Controller_memsize = 3'b010;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        repeat (3) tick();
        check("rst_req", 32'(dmem_req), 32'h0);
        check("rst_kick", 32'(MEM_kick_up), 32'h0);
        check("rst_result", MEM_result, 32'h0);
        check("rst_busy", 32'(MEM_busy), 32'h0);
        check("rst_addr", dmem_addr, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        check("rst_fault", 32'(MEM_fault), 32'h0);
`endif
        reset = 1'b0;
        tick();
        $display("txn reset: outputs idle");

        // Pass-through: pulse one cycle after the kick, value passed unchanged.
        kick(32'h1234_5678, 32'h0, 1'b0, 1'b0, 3'b010);
        check("pt_kick", 32'(MEM_kick_up), 32'h1);
        check("pt_result", MEM_result, 32'h1234_5678);
        check("pt_req", 32'(dmem_req), 32'h0);
        tick();
        check("pt_kick_end", 32'(MEM_kick_up), 32'h0);
        check("pt_hold", MEM_result, 32'h1234_5678);
        $display("txn pass-through: result=0x%08h", MEM_result);

        // SH to 0x202 with read also set (write wins), zero-wait ack.
        kick(32'h0000_0202, 32'hDEAD_BEEF, 1'b1, 1'b1, 3'b001);
        check("sh_req", 32'(dmem_req), 32'h1);
        check("sh_busy", 32'(MEM_busy), 32'h1);
        check("sh_we", 32'(dmem_we), 32'h1);
        check("sh_addr", dmem_addr, 32'h0000_0200);
        check("sh_be", 32'(dmem_be), 32'hC);
        check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("sh_kick", 32'(MEM_kick_up), 32'h1);
        check("sh_result", MEM_result, 32'h0);
        check("sh_req_off", 32'(dmem_req), 32'h0);
        check("sh_we_off", 32'(dmem_we), 32'h0);
        check("sh_wdata_off", dmem_wdata, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        check("sh_fault", 32'(MEM_fault), 32'h0);
`endif
        tick();
        $display("txn store-half: be=1100 wdata=0xbeefbeef");

        // Timeout: no ack, a stray kick during REQ, late ack after the abort.
        kick(32'h0000_0300, 32'h0, 1'b1, 1'b0, 3'b010);
        req_cycles = 0;
        pulses = 0;
        for (int i = 0; i < 22; i++) begin
            if (dmem_req) req_cycles++;
            if (MEM_kick_up) begin
                pulses++;
                check("to_result", MEM_result, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
                check("to_fault", 32'(MEM_fault), 32'h1);
`endif
            end
            if (i == 10) check("to_addr_stable", dmem_addr, 32'h0000_0300);
            ALU_kick_up = (i == 5);
            dmem_ack = (i >= 16 && i <= 18);
            tick();
        end
        ALU_kick_up = 1'b0;
        dmem_ack = 1'b0;
        check("to_req_cycles", 32'(req_cycles), 32'd16);
        check("to_pulses", 32'(pulses), 32'd1);
        check("to_req_end", 32'(dmem_req), 32'h0);
        $display("txn timeout: req_cycles=%0d pulses=%0d", req_cycles, pulses);

        // LB at 0x103, three wait cycles then ack.
        kick(32'h0000_0103, 32'h0, 1'b1, 1'b0, 3'b000);
        check("lb_req", 32'(dmem_req), 32'h1);
        check("lb_we", 32'(dmem_we), 32'h0);
        check("lb_addr", dmem_addr, 32'h0000_0100);
        check("lb_be", 32'(dmem_be), 32'h8);
        repeat (3) tick();
        check("lb_req_wait", 32'(dmem_req), 32'h1);
        check("lb_kick_wait", 32'(MEM_kick_up), 32'h0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h80AB_CDEF;
        tick();
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        check("lb_kick", 32'(MEM_kick_up), 32'h1);
        check("lb_result", MEM_result, 32'hFFFF_FF80);
        // A kick during DONE must be ignored.
        ALU_kick_up = 1'b1;
        ALU_result = 32'h0000_0500;
        Controller_memread = 1'b1;
        tick();
        ALU_kick_up = 1'b0;
        Controller_memread = 1'b0;
        check("lb_no_second", 32'(MEM_kick_up), 32'h0);
        check("lb_hold", MEM_result, 32'hFFFF_FF80);
        tick();
        check("lb_no_req", 32'(dmem_req), 32'h0);
        $display("txn load-byte: result=0x%08h", MEM_result);

        // Asynchronous reset in the middle of a request.
        kick(32'h0000_0400, 32'h0, 1'b1, 1'b0, 3'b010);
        check("rr_req", 32'(dmem_req), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("rr_req_drop", 32'(dmem_req), 32'h0);
        check("rr_addr", dmem_addr, 32'h0);
        check("rr_result", MEM_result, 32'h0);
        check("rr_busy", 32'(MEM_busy), 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // LHU at 0x2, zero-wait ack.
        kick(32'h0000_0002, 32'h0, 1'b1, 1'b0, 3'b101);
        check("lhu_addr", dmem_addr, 32'h0);
        check("lhu_be", 32'(dmem_be), 32'hC);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h8001_0000;
        tick();
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        check("lhu_kick", 32'(MEM_kick_up), 32'h1);
        check("lhu_result", MEM_result, 32'h0000_8001);
        tick();
        $display("txn reset+lhu: result=0x%08h", MEM_result);

`ifdef MEM_MISALIGN_TRAP_EN
        // Misaligned LW is trapped without a memory request.
        kick(32'h0000_0101, 32'h0, 1'b1, 1'b0, 3'b010);
        check("mis_req", 32'(dmem_req), 32'h0);
        check("mis_kick", 32'(MEM_kick_up), 32'h1);
        check("mis_fault", 32'(MEM_fault), 32'h1);
        check("mis_result", MEM_result, 32'h0);
        tick();
        check("mis_fault_hold", 32'(MEM_fault), 32'h1);
        $display("txn misaligned-lw: fault=%0d", MEM_fault);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
